// File: rtl/wb_regfile_pkg.sv
// Shared pipeline types: the MEM/WB register layout, register-file sizing and
// the debugger access states.
package pipeline_types;

  localparam int unsigned NumRegs      = 32;
  localparam int unsigned RegWidth     = 32;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned InstretWidth = 64;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegWidth-1:0]     value;
    logic                    wen;
  } rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
  } mem_wb_t;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_ACCESS,
    DBG_ACK,
    DBG_DONE
  } dbg_state_e;

endpackage

// File: rtl/wb_regfile_rf.sv
// Integer register storage with x0 held at zero and three read ports.
// Bypass from the write port applies only while iByp qualifies the write.
module regfile_2r1w
  import pipeline_types::*;
#(
  parameter int unsigned NUM_REGS  = NumRegs,
  parameter int unsigned REG_W     = RegWidth,
  parameter int unsigned REG_AW    = RegAddrWidth
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iWe,
  input  logic [REG_AW-1:0] iWaddr,
  input  logic [REG_W-1:0]  iWdata,
  input  logic              iByp,
  input  logic [REG_AW-1:0] iRaddr1,
  input  logic [REG_AW-1:0] iRaddr2,
  input  logic [REG_AW-1:0] iRaddr3,
  output logic [REG_W-1:0]  oRdata1,
  output logic [REG_W-1:0]  oRdata2,
  output logic [REG_W-1:0]  oRdata3
);

  logic [REG_W-1:0] r_mem [NUM_REGS];
  logic             w_byp;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (iWe && (iWaddr != '0)) begin
      r_mem[iWaddr] <= iWdata;
    end
  end

  // Debug writes use the same write port but must not forward into the read ports.
  assign w_byp = iByp & iWe;

  always_comb begin
    if (iRaddr1 == '0)                     oRdata1 = '0;
    else if (w_byp && (iWaddr == iRaddr1)) oRdata1 = iWdata;
    else                                   oRdata1 = r_mem[iRaddr1];
  end

  always_comb begin
    if (iRaddr2 == '0)                     oRdata2 = '0;
    else if (w_byp && (iWaddr == iRaddr2)) oRdata2 = iWdata;
    else                                   oRdata2 = r_mem[iRaddr2];
  end

  always_comb begin
    if (iRaddr3 == '0)                     oRdata3 = '0;
    else if (w_byp && (iWaddr == iRaddr3)) oRdata3 = iWdata;
    else                                   oRdata3 = r_mem[iRaddr3];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits MEM/WB results, counts retired instructions and
// arbitrates debugger register accesses behind pipeline writeback.
module wb_regfile
  import pipeline_types::*;
#(
  parameter int unsigned NUM_REGS  = NumRegs,
  parameter int unsigned REG_W     = RegWidth,
  parameter int unsigned REG_AW    = RegAddrWidth,
  parameter int unsigned INSTRET_W = InstretWidth
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStall,
  input  logic                 iFlush,
  input  mem_wb_t              iME,
  input  logic [REG_AW-1:0]    iAddrRs1,
  input  logic [REG_AW-1:0]    iAddrRs2,
  output logic [REG_W-1:0]     oRs1,
  output logic [REG_W-1:0]     oRs2,
  input  logic                 iDbgReq,
  input  logic                 iDbgWe,
  input  logic [REG_AW-1:0]    iDbgAddr,
  input  logic [REG_W-1:0]     iDbgWdata,
  output logic                 oDbgAck,
  output logic [REG_W-1:0]     oDbgRdata,
  output logic [INSTRET_W-1:0] oInstret,
  output logic                 oCommitting
);

  dbg_state_e            r_state;
  logic                  r_dbg_we;
  logic [REG_AW-1:0]     r_dbg_addr;
  logic [REG_W-1:0]      r_dbg_wdata;
  logic [REG_W-1:0]      r_dbg_rdata;
  logic [INSTRET_W-1:0]  r_instret;

  logic                  w_retire;
  logic                  w_commit;
  logic                  w_dbg_go;
  logic                  w_dbg_wr;
  logic                  w_rf_we;
  logic [REG_AW-1:0]     w_rf_waddr;
  logic [REG_W-1:0]      w_rf_wdata;
  logic [REG_W-1:0]      w_dbg_rd;

  assign w_retire    = iME.valid & ~iStall & ~iFlush;
  assign w_commit    = w_retire & iME.rd.wen & (iME.rd.addr != '0);
  assign oCommitting = w_commit;

  // The debug access only proceeds in a cycle without a commit, so the two
  // writers never collide on the single write port.
  assign w_dbg_go   = (r_state == DBG_ACCESS) & ~w_commit;
  assign w_dbg_wr   = w_dbg_go & r_dbg_we;
  assign w_rf_we    = w_commit | w_dbg_wr;
  assign w_rf_waddr = w_commit ? iME.rd.addr  : r_dbg_addr;
  assign w_rf_wdata = w_commit ? iME.rd.value : r_dbg_wdata;

  regfile_2r1w #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .REG_AW   (REG_AW)
  ) u_rf (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWe     (w_rf_we),
    .iWaddr  (w_rf_waddr),
    .iWdata  (w_rf_wdata),
    .iByp    (w_commit),
    .iRaddr1 (iAddrRs1),
    .iRaddr2 (iAddrRs2),
    .iRaddr3 (r_dbg_addr),
    .oRdata1 (oRs1),
    .oRdata2 (oRs2),
    .oRdata3 (w_dbg_rd)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= DBG_IDLE;
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        DBG_IDLE: begin
          if (iDbgReq) begin
            r_dbg_we    <= iDbgWe;
            r_dbg_addr  <= iDbgAddr;
            r_dbg_wdata <= iDbgWdata;
            r_state     <= DBG_ACCESS;
          end
        end
        DBG_ACCESS: begin
          if (w_dbg_go) begin
            if (!r_dbg_we) begin
              r_dbg_rdata <= w_dbg_rd;
            end
            r_state <= DBG_ACK;
          end
        end
        DBG_ACK: r_state <= DBG_DONE;
        DBG_DONE: begin
          if (!iDbgReq) begin
            r_state <= DBG_IDLE;
          end
        end
        default: r_state <= DBG_IDLE;
      endcase
    end
  end

  assign oDbgAck   = (r_state == DBG_ACK);
  assign oDbgRdata = r_dbg_rdata;
  assign oInstret  = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a per-cycle reference model of the
// register file, retire counter and debugger handshake.
module tb_wb_regfile;
  import pipeline_types::*;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStall;
  logic        iFlush;
  mem_wb_t     iME;
  logic [4:0]  iAddrRs1;
  logic [4:0]  iAddrRs2;
  logic [31:0] oRs1;
  logic [31:0] oRs2;
  logic        iDbgReq;
  logic        iDbgWe;
  logic [4:0]  iDbgAddr;
  logic [31:0] iDbgWdata;
  logic        oDbgAck;
  logic [31:0] oDbgRdata;
  logic [63:0] oInstret;
  logic        oCommitting;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 iClk = ~iClk;

  wb_regfile dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStall      (iStall),
    .iFlush      (iFlush),
    .iME         (iME),
    .iAddrRs1    (iAddrRs1),
    .iAddrRs2    (iAddrRs2),
    .oRs1        (oRs1),
    .oRs2        (oRs2),
    .iDbgReq     (iDbgReq),
    .iDbgWe      (iDbgWe),
    .iDbgAddr    (iDbgAddr),
    .iDbgWdata   (iDbgWdata),
    .oDbgAck     (oDbgAck),
    .oDbgRdata   (oDbgRdata),
    .oInstret    (oInstret),
    .oCommitting (oCommitting)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus debugger request progress.
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic [31:0] m_rdata;
  bit          m_pend, m_ack, m_wait, m_we;
  logic [4:0]  m_a;
  logic [31:0] m_d;

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit c);
    if (a == 5'd0) return 32'd0;
    if (c && (a == iME.rd.addr)) return iME.rd.value;
    return m_regs[a];
  endfunction

  always @(negedge iClk) begin
    bit commit, retire;
    if (iRst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instret = 64'd0;
      m_rdata   = 32'd0;
      m_pend = 0; m_ack = 0; m_wait = 0; m_we = 0;
      m_a = 5'd0; m_d = 32'd0;
    end else begin
      retire = iME.valid && !iStall && !iFlush;
      commit = retire && iME.rd.wen && (iME.rd.addr != 5'd0);
      check("rs1", oRs1, m_read(iAddrRs1, commit));
      check("rs2", oRs2, m_read(iAddrRs2, commit));
      check("committing", oCommitting, commit);
      check("instret", oInstret, m_instret);
      check("dbg_ack", oDbgAck, m_ack);
      check("dbg_rdata", oDbgRdata, m_rdata);
      if (m_ack) begin
        m_ack = 0; m_wait = 1;
      end else if (m_wait) begin
        if (!iDbgReq) m_wait = 0;
      end else if (m_pend) begin
        if (!commit) begin
          if (m_we) begin
            if (m_a != 5'd0) m_regs[m_a] = m_d;
          end else begin
            m_rdata = m_read(m_a, 0);
          end
          m_pend = 0; m_ack = 1;
        end
      end else if (iDbgReq) begin
        m_pend = 1; m_we = iDbgWe; m_a = iDbgAddr; m_d = iDbgWdata;
      end
      if (commit) m_regs[iME.rd.addr] = iME.rd.value;
      if (retire) m_instret = m_instret + 64'd1;
    end
  end

  task automatic next();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_me(input bit v, input bit wen, input logic [4:0] a, input logic [31:0] val);
    iME.valid    = v;
    iME.rd.wen   = wen;
    iME.rd.addr  = a;
    iME.rd.value = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acks, ack_at;
    logic [31:0] rd_at_ack;
    iRst = 1'b1; iStall = 1'b0; iFlush = 1'b0; iME = '0;
    iAddrRs1 = 5'd0; iAddrRs2 = 5'd0;
    iDbgReq = 1'b0; iDbgWe = 1'b0; iDbgAddr = 5'd0; iDbgWdata = 32'd0;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    #3;
    check("rst_instret", oInstret, 64'd0);
    check("rst_ack", oDbgAck, 1'b0);
    check("rst_rdata", oDbgRdata, 32'd0);

    // x5 = 0x1234 and seven retirements, then a reset pulse mid-run
    next();
    iAddrRs1 = 5'd5;
    set_me(1, 1, 5'd5, 32'h1234);
    next();
    set_me(1, 0, 5'd9, 32'hAAAA);
    repeat (6) next();
    set_me(0, 0, 5'd0, 32'd0);
    #3;
    check("pre_rst_x5", oRs1, 32'h1234);
    check("pre_rst_instret", oInstret, 64'd7);
    next();
    iRst = 1'b1;
    #3;
    check("rst_pulse_x5", oRs1, 32'd0);
    check("rst_pulse_instret", oInstret, 64'd0);
    check("rst_pulse_ack", oDbgAck, 1'b0);
    next();
    iRst = 1'b0;

    // same-cycle bypass, then stored value
    set_me(1, 1, 5'd5, 32'hDEADBEEF);
    #3;
    check("bypass_rs1", oRs1, 32'hDEADBEEF);
    check("bypass_committing", oCommitting, 1'b1);
    next();
    set_me(0, 0, 5'd0, 32'd0);
    #3;
    check("stored_rs1", oRs1, 32'hDEADBEEF);
    next();

    // write to x0 still retires
    iAddrRs1 = 5'd0;
    set_me(1, 1, 5'd0, 32'hFFFFFFFF);
    #3;
    check("x0_rs1", oRs1, 32'd0);
    check("x0_committing", oCommitting, 1'b0);
    next();
    set_me(0, 0, 5'd0, 32'd0);
    #3;
    check("x0_instret", oInstret, 64'd2);
    next();

    // stall for two cycles: single write, single retire
    iAddrRs2 = 5'd3;
    set_me(1, 1, 5'd3, 32'h33);
    iStall = 1'b1;
    #3;
    check("stall_committing", oCommitting, 1'b0);
    next();
    next();
    iStall = 1'b0;
    #3;
    check("unstall_committing", oCommitting, 1'b1);
    next();
    set_me(0, 0, 5'd0, 32'd0);
    #3;
    check("stall_x3", oRs2, 32'h33);
    check("stall_instret", oInstret, 64'd3);
    next();

    // flush, stall+flush, then an invalid entry with wen set
    set_me(1, 1, 5'd3, 32'h77);
    iFlush = 1'b1;
    #3;
    check("flush_committing", oCommitting, 1'b0);
    next();
    iStall = 1'b1;
    next();
    iStall = 1'b0; iFlush = 1'b0;
    set_me(0, 1, 5'd3, 32'h99);
    #3;
    check("bubble_committing", oCommitting, 1'b0);
    next();
    set_me(0, 0, 5'd0, 32'd0);
    #3;
    check("flush_x3", oRs2, 32'h33);
    check("flush_instret", oInstret, 64'd3);
    next();

    // debug write x10 deferred by three consecutive commits, request held high
    acks = 0; ack_at = -1;
    iAddrRs1 = 5'd10;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        iDbgReq = 1'b1; iDbgWe = 1'b1; iDbgAddr = 5'd10; iDbgWdata = 32'h55AA;
      end
      if (k >= 1 && k <= 3) set_me(1, 1, 5'(k), 32'h100 + k);
      else                  set_me(0, 0, 5'd0, 32'd0);
      #3;
      if (oDbgAck) begin acks++; ack_at = k; end
      if (k == 4) check("dbgwr_not_yet", oRs1, 32'd0);
      if (k == 5) check("dbgwr_visible", oRs1, 32'h55AA);
      next();
    end
    check("dbgwr_ack_count", acks, 1);
    check("dbgwr_ack_cycle", ack_at, 5);
    iDbgReq = 1'b0; iDbgWe = 1'b0;
    next();

    // debug read x10 with no commits: two-cycle latency
    acks = 0; ack_at = -1; rd_at_ack = 32'd0;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin iDbgReq = 1'b1; iDbgAddr = 5'd10; end
      if (k == 3) iDbgReq = 1'b0;
      #3;
      if (oDbgAck) begin acks++; ack_at = k; rd_at_ack = oDbgRdata; end
      next();
    end
    check("dbgrd_ack_count", acks, 1);
    check("dbgrd_ack_cycle", ack_at, 2);
    check("dbgrd_data", rd_at_ack, 32'h55AA);

    // debug read x7 while x7 is committed in the access cycle
    acks = 0; ack_at = -1; rd_at_ack = 32'd0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin iDbgReq = 1'b1; iDbgAddr = 5'd7; end
      if (k == 4) iDbgReq = 1'b0;
      if (k == 1) set_me(1, 1, 5'd7, 32'h42);
      else        set_me(0, 0, 5'd0, 32'd0);
      #3;
      if (oDbgAck) begin acks++; ack_at = k; rd_at_ack = oDbgRdata; end
      next();
    end
    check("defer_ack_count", acks, 1);
    check("defer_ack_cycle", ack_at, 3);
    check("defer_data", rd_at_ack, 32'h42);

    next();
    next();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
